controle_ciclo: RTL

//  Cycle sequencer: the initiator side of the phase start/ativa handshake.

---
 rtl/controle_ciclo.sv | 118 +++++++++++
 1 files changed

// File: rtl/controle_ciclo.sv
// Washing-machine cycle sequencer: drives wash/rinse/spin starts in order,
// watches each phase's ativa for completion, and traps timeouts and door-open aborts.
module controle_ciclo #(
  parameter int unsigned TIMEOUT_RESPOSTA = 4,
  parameter int unsigned TIMEOUT_FASE     = 64,
  parameter int unsigned CNT_W            = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       porta_fechada,
  input  logic       lavagem_ativa,
  input  logic       enxague_ativa,
  input  logic       centrifugacao_ativa,
  output logic       start_lavagem,
  output logic       start_enxague,
  output logic       start_centrifugacao,
  output logic [2:0] fase_atual,
  output logic       ciclo_concluido,
  output logic       erro
);

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    LAVAGEM       = 3'd1,
    ENXAGUE       = 3'd2,
    CENTRIFUGACAO = 3'd3,
    CONCLUIDO     = 3'd4,
    ERRO          = 3'd5
  } estado_e;

  estado_e          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             visto_q, visto_d;
  logic             ativa_c;

  // Only the current phase's busy flag is observed.
  always_comb begin
    ativa_c = 1'b0;
    case (estado_q)
      LAVAGEM:       ativa_c = lavagem_ativa;
      ENXAGUE:       ativa_c = enxague_ativa;
      CENTRIFUGACAO: ativa_c = centrifugacao_ativa;
      default:       ativa_c = 1'b0;
    endcase
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    visto_d  = visto_q;
    cnt_inc  = cnt_q + CNT_W'(1);
    case (estado_q)
      OCIOSO: begin
        if (iniciar && porta_fechada) estado_d = LAVAGEM;
      end
      LAVAGEM, ENXAGUE, CENTRIFUGACAO: begin
        // Door check outranks both timeouts and phase completion.
        if (!porta_fechada) begin
          estado_d = ERRO;
        end else if (!visto_q) begin
          if (ativa_c) begin
            visto_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(TIMEOUT_RESPOSTA)) estado_d = ERRO;
          end
        end else if (ativa_c) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT_FASE)) estado_d = ERRO;
        end else if (estado_q == LAVAGEM) begin
          estado_d = ENXAGUE;
        end else if (estado_q == ENXAGUE) begin
          estado_d = CENTRIFUGACAO;
        end else begin
          estado_d = CONCLUIDO;
        end
      end
      CONCLUIDO: estado_d = OCIOSO;
      ERRO: begin
        if (iniciar && porta_fechada) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
    // Any state change starts the next phase with a clean counter and visto flag.
    if (estado_d != estado_q) begin
      cnt_d   = '0;
      visto_d = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q            <= OCIOSO;
      cnt_q               <= '0;
      visto_q             <= 1'b0;
      start_lavagem       <= 1'b0;
      start_enxague       <= 1'b0;
      start_centrifugacao <= 1'b0;
      fase_atual          <= 3'd0;
      ciclo_concluido     <= 1'b0;
      erro                <= 1'b0;
    end else begin
      estado_q            <= estado_d;
      cnt_q               <= cnt_d;
      visto_q             <= visto_d;
      start_lavagem       <= (estado_d == LAVAGEM);
      start_enxague       <= (estado_d == ENXAGUE);
      start_centrifugacao <= (estado_d == CENTRIFUGACAO);
      fase_atual          <= estado_d;
      ciclo_concluido     <= (estado_d == CONCLUIDO);
      erro                <= (estado_d == ERRO);
    end
  end

endmodule
